io_port_bank: RTL and testbench
===============================

# io_port_bank

Parametrised memory-mapped I/O bank that replaces the single fixed 8-bit in/out port pair at 0x800 on the single-cycle ARM data bus. It provides NCH independent channels. Each channel has:
- a synchronised input port;
- an output register with set/clear/toggle write modes;
- optional sticky edge-detect flags with an interrupt line.

It sits beside dmem and is selected by address decode. Reads are combinational so the single-cycle core can return its data the same cycle.

## Interface
- WIDTH, 8: bits per channel, 1..32.
- NCH, 2: channel count, 1..8.
- BASE, 32'h800: byte base address; must be 32-byte aligned.
- SYNC_STAGES, 2: input synchroniser depth, ≥2.

- clk  in  1  system clock, rising edge.
- resetE  in  1  asynchronous, active-low reset.
- addr  in  32  byte address (core DataAdr).
- wdata  in  32  write data (core WriteData).
- we  in  1  write strobe (core MemWrite).
- re  in  1  read strobe (core MemtoReg).
- rdata  out  32  read data, combinational.
- hit  out  1  addr lies within the bank window; drives the core read-data mux select.
- pin_in  in  NCH*WIDTH  external inputs, asynchronous; channel c occupies [c*WIDTH +: WIDTH].
- pin_out  out  NCH*WIDTH  registered outputs.
- irq  out  1  OR of all enabled edge flags; constant 0 without IOBANK_EDGE_EN.

## Operation
- Window: hit = (addr ≥ BASE) && (addr < BASE + 32*NCH).
- Decode: channel = (addr−BASE)[7:5]; register index = addr[4:2]; addr[1:0] ignored.
- Per-channel registers, by word index:
  - 0 IN: read-only; synchronised input.
  - 1 OUT: read/write; the output register.
  - 2 SET: write-only; OUT |= d.
  - 3 CLR: write-only; OUT &= ~d.
  - 4 TGL: write-only; OUT ^= d.
  - 5 RISE: sticky; write-1-to-clear.
  - 6 FALL: sticky; write-1-to-clear.
  - 7 reserved.
- Write-only and reserved registers read 0. Writes to IN and reserved are ignored.
- d = wdata[WIDTH-1:0]. Reads are zero-extended to 32 bits.
- rdata = 0 when !hit or !re. Reads have no side effects.
- Synchroniser: SYNC_STAGES flops per bit produce s. A prev register p holds s delayed one cycle.
- Edge detect: rise = s & ~p, fall = ~s & p; each is ORed into its sticky flag.
- Arming counter:
  - Counts SYNC_STAGES+1 cycles after reset release, then asserts armed.
  - Edge detection is gated by armed, so input levels present at reset never create flags.
- Simultaneous W1C and new edge on the same bit: set wins; the flag stays 1.
- Writes with we && !hit do nothing. we and re together is legal; the read returns pre-write state.

## Timing
- Reset (resetE=0, async), all outputs and state cleared:
  - pin_out = 0.
  - Synchroniser flops, p, flags and arming counter = 0.
  - irq = 0.
- A reset asserted mid-operation clears all of the above immediately.
- An OUT/SET/CLR/TGL write takes effect at the clk edge where we=1; pin_out changes after that edge.
- pin_in to IN: SYNC_STAGES edges of latency.
- RISE/FALL flag: set at the edge after s changes, i.e. SYNC_STAGES+1 edges after a pin_in change.
- irq: combinational from the flags, so it asserts in the same cycle as the flag.
- W1C: flag clears at the write edge. irq deasserts once no flags remain.

## Configuration
- IOBANK_EDGE_EN defined: the following are implemented:
  - RISE/FALL flags;
  - the prev register;
  - the arming counter;
  - irq.
- IOBANK_EDGE_EN undefined:
  - Word indices 5 and 6 read 0 and writes to them are ignored.
  - irq is tied to 0.
  - The flag logic, prev register and arming counter are not synthesised.
- IN/OUT/SET/CLR/TGL behave identically either way.

## Structure
- Package iobank_pkg holds:
  - register index localparams (REG_IN … REG_FALL);
  - CH_STRIDE = 32;
  - a typedef enum for the register index.
- Sub-module iobank_sync: WIDTH-wide, SYNC_STAGES-deep synchroniser with async active-low reset. Instantiate one per channel in a generate loop.
- Top-level integration: the bank's hit replaces cmp2 in the core's read-data mux select.

## Test plan
- Reset, then write 0xA5 to BASE+0x04 (ch0 OUT) → pin_out[7:0]=0xA5 after one edge; read BASE+0x04 returns 0x000000A5.
- Starting from OUT=0xA5:
  - SET 0x0F at +0x08 → OUT=0xAF;
  - CLR 0xA0 at +0x0C → OUT=0x0F;
  - TGL 0xFF at +0x10 → OUT=0xF0.
  - Also verify that ch1 is unaffected by all three writes.
- Drive pin_in ch1 = 0x3C:
  - read BASE+0x20 before SYNC_STAGES edges → 0x00;
  - read at SYNC_STAGES edges → 0x3C.
- Edge flags (IOBANK_EDGE_EN defined):
  - ch0 bit2 0→1 → RISE (+0x14) reads 0x04 and irq=1;
  - write 0x04 to +0x14 → flag 0, irq=0;
  - repeat with a same-cycle new edge → flag remains 1.
- Hold pin_in=0xFF through reset and release → no RISE flags and irq=0; a later 1→0 transition sets FALL.
- Address outside the window: accesses to BASE−4 and BASE+32*NCH give hit=0 and rdata=0, and pin_out is unchanged.

Source files
------------

// File: rtl/iobank_pkg.sv
// Shared constants for the memory-mapped I/O port bank: register word indices and channel stride.
package iobank_pkg;

    localparam int unsigned CH_STRIDE = 32;

    localparam logic [2:0] REG_IN   = 3'd0;
    localparam logic [2:0] REG_OUT  = 3'd1;
    localparam logic [2:0] REG_SET  = 3'd2;
    localparam logic [2:0] REG_CLR  = 3'd3;
    localparam logic [2:0] REG_TGL  = 3'd4;
    localparam logic [2:0] REG_RISE = 3'd5;
    localparam logic [2:0] REG_FALL = 3'd6;

    typedef enum logic [2:0] {
        RegIn   = 3'd0,
        RegOut  = 3'd1,
        RegSet  = 3'd2,
        RegClr  = 3'd3,
        RegTgl  = 3'd4,
        RegRise = 3'd5,
        RegFall = 3'd6,
        RegRsvd = 3'd7
    } reg_idx_e;

endpackage

// File: rtl/iobank_sync.sv
// Multi-stage flop synchroniser for one channel of asynchronous input pins.
module iobank_sync #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetE,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge resetE) begin
        if (!resetE) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of NCH I/O channels with set/clear/toggle output writes.
// Define IOBANK_EDGE_EN to build the sticky RISE/FALL flags, arming counter and irq.
module io_port_bank
    import iobank_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NCH         = 2,
    parameter logic [31:0] BASE        = 32'h800,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetE,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 we,
    input  logic                 re,
    output logic [31:0]          rdata,
    output logic                 hit,
    input  logic [NCH*WIDTH-1:0] pin_in,
    output logic [NCH*WIDTH-1:0] pin_out,
    output logic                 irq
);

    localparam logic [32:0] WinLo = {1'b0, BASE};
    localparam logic [32:0] WinHi = {1'b0, BASE} + 33'(CH_STRIDE * NCH);

    logic [31:0]      offset;
    logic [2:0]       ch;
    logic [2:0]       idx;
    logic [WIDTH-1:0] d;
    logic             wr;
    logic [WIDTH-1:0] s      [NCH];
    logic [WIDTH-1:0] out_q  [NCH];
    logic [WIDTH-1:0] out_d  [NCH];

    assign hit    = ({1'b0, addr} >= WinLo) && ({1'b0, addr} < WinHi);
    assign offset = addr - BASE;
    assign ch     = offset[7:5];
    assign idx    = addr[4:2];
    assign d      = wdata[WIDTH-1:0];
    assign wr     = we && hit;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata, offset};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        iobank_sync #(
            .WIDTH      (WIDTH),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .resetE(resetE),
            .din   (pin_in[c*WIDTH +: WIDTH]),
            .dout  (s[c])
        );
        assign pin_out[c*WIDTH +: WIDTH] = out_q[c];
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            out_d[c] = out_q[c];
            if (wr && ch == 3'(c)) begin
                case (idx)
                    REG_OUT: out_d[c] = d;
                    REG_SET: out_d[c] = out_q[c] | d;
                    REG_CLR: out_d[c] = out_q[c] & ~d;
                    REG_TGL: out_d[c] = out_q[c] ^ d;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetE) begin
        if (!resetE) begin
            for (int c = 0; c < NCH; c++) out_q[c] <= '0;
        end else begin
            out_q <= out_d;
        end
    end

`ifdef IOBANK_EDGE_EN
    localparam int unsigned ArmCnt = SYNC_STAGES + 1;
    localparam int unsigned ArmW   = $clog2(ArmCnt + 1);

    logic [ArmW-1:0]  arm_q;
    logic             armed;
    logic [WIDTH-1:0] p_q    [NCH];
    logic [WIDTH-1:0] rise_q [NCH];
    logic [WIDTH-1:0] fall_q [NCH];
    logic [WIDTH-1:0] rise_d [NCH];
    logic [WIDTH-1:0] fall_d [NCH];
    logic [NCH-1:0]   ch_flag;

    // Synchroniser contents left over from reset must not look like edges.
    assign armed = (arm_q == ArmW'(ArmCnt));

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            rise_d[c] = rise_q[c];
            fall_d[c] = fall_q[c];
            if (wr && ch == 3'(c) && idx == REG_RISE) rise_d[c] = rise_q[c] & ~d;
            if (wr && ch == 3'(c) && idx == REG_FALL) fall_d[c] = fall_q[c] & ~d;
            // New edges are ORed in after the W1C so set wins.
            if (armed) begin
                rise_d[c] = rise_d[c] | (s[c] & ~p_q[c]);
                fall_d[c] = fall_d[c] | (~s[c] & p_q[c]);
            end
            ch_flag[c] = |{rise_q[c], fall_q[c]};
        end
    end

    assign irq = |ch_flag;

    always_ff @(posedge clk or negedge resetE) begin
        if (!resetE) begin
            arm_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                p_q[c]    <= '0;
                rise_q[c] <= '0;
                fall_q[c] <= '0;
            end
        end else begin
            if (!armed) arm_q <= arm_q + 1'b1;
            p_q    <= s;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (hit && re) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch == 3'(c)) begin
                    case (idx)
                        REG_IN:   rdata = 32'(s[c]);
                        REG_OUT:  rdata = 32'(out_q[c]);
`ifdef IOBANK_EDGE_EN
                        REG_RISE: rdata = 32'(rise_q[c]);
                        REG_FALL: rdata = 32'(fall_q[c]);
`endif
                        default:  ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank with a queue-based expected-value scoreboard.
module tb_io_port_bank;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NCH   = 2;
    localparam int unsigned SYNC  = 2;
    localparam logic [31:0] BASE  = 32'h800;

    logic                 clk;
    logic                 resetE;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic                 we;
    logic                 re;
    logic [31:0]          rdata;
    logic                 hit;
    logic [NCH*WIDTH-1:0] pin_in;
    logic [NCH*WIDTH-1:0] pin_out;
    logic                 irq;

    io_port_bank #(
        .WIDTH      (WIDTH),
        .NCH        (NCH),
        .BASE       (BASE),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk    (clk),
        .resetE (resetE),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .re     (re),
        .rdata  (rdata),
        .hit    (hit),
        .pin_in (pin_in),
        .pin_out(pin_out),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, required none", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h, required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] dat);
        @(negedge clk);
        addr  = a;
        wdata = dat;
        we    = 1'b1;
        re    = 1'b0;
        @(negedge clk);
        we    = 1'b0;
    endtask

    // Combinational read in the current low phase; consumes 1 time unit.
    task automatic peek(input logic [31:0] a, output logic [31:0] dat, output logic h);
        addr = a;
        we   = 1'b0;
        re   = 1'b1;
        #1;
        dat  = rdata;
        h    = hit;
        re   = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        h;

        resetE = 1'b0;
        addr   = '0;
        wdata  = '0;
        we     = 1'b0;
        re     = 1'b0;
        pin_in = '0;

        expect_val("rst_pin_out", 32'h0);
        expect_val("rst_irq", 32'h0);
        repeat (3) @(negedge clk);
        compare(32'(pin_out));
        compare(32'(irq));
        resetE = 1'b1;

        // Output register write modes
        expect_val("out_write", 32'h00A5);
        wr(BASE + 32'h04, 32'hA5);
        compare(32'(pin_out));
        expect_val("out_read", 32'h0000_00A5);
        expect_val("out_hit", 32'h1);
        peek(BASE + 32'h04, rd, h);
        compare(rd);
        compare(32'(h));

        expect_val("set", 32'h00AF);
        wr(BASE + 32'h08, 32'h0F);
        compare(32'(pin_out));
        expect_val("clr", 32'h000F);
        wr(BASE + 32'h0C, 32'hA0);
        compare(32'(pin_out));
        expect_val("tgl", 32'h00F0);
        wr(BASE + 32'h10, 32'hFF);
        compare(32'(pin_out));

        expect_val("set_reads_zero", 32'h0);
        @(negedge clk);
        peek(BASE + 32'h08, rd, h);
        compare(rd);

        expect_val("ch1_out", 32'h5AF0);
        wr(BASE + 32'h24, 32'hFFFF_FF5A);
        compare(32'(pin_out));

        // Input synchroniser latency on ch1
        @(negedge clk);
        pin_in[15:8] = 8'h3C;
        expect_val("in_early", 32'h0);
        @(negedge clk);
        peek(BASE + 32'h20, rd, h);
        compare(rd);
        expect_val("in_sync", 32'h3C);
        @(negedge clk);
        peek(BASE + 32'h20, rd, h);
        compare(rd);

        expect_val("no_re_zero", 32'h0);
        addr = BASE + 32'h20;
        re   = 1'b0;
        #1;
        compare(rdata);

        // Accesses outside the window
        wr(BASE - 32'h4, 32'hFF);
        wr(BASE + 32'h40, 32'hFF);
        wr(BASE + 32'h44, 32'hFF);
        expect_val("oow_pin_out", 32'h5AF0);
        compare(32'(pin_out));
        expect_val("below_rdata", 32'h0);
        expect_val("below_hit", 32'h0);
        @(negedge clk);
        peek(BASE - 32'h4, rd, h);
        compare(rd);
        compare(32'(h));
        expect_val("above_rdata", 32'h0);
        expect_val("above_hit", 32'h0);
        @(negedge clk);
        peek(BASE + 32'h40, rd, h);
        compare(rd);
        compare(32'(h));
        expect_val("last_word_hit", 32'h1);
        expect_val("rsvd_reads_zero", 32'h0);
        @(negedge clk);
        peek(BASE + 32'h3C, rd, h);
        compare(32'(h));
        compare(rd);

`ifdef IOBANK_EDGE_EN
        // ch1 saw 0->3C after arming
        expect_val("ch1_rise", 32'h3C);
        expect_val("ch1_irq", 32'h1);
        @(negedge clk);
        peek(BASE + 32'h34, rd, h);
        compare(rd);
        compare(32'(irq));
        wr(BASE + 32'h34, 32'hFF);
        expect_val("ch1_rise_clr", 32'h0);
        expect_val("ch1_irq_clr", 32'h0);
        peek(BASE + 32'h34, rd, h);
        compare(rd);
        compare(32'(irq));

        @(negedge clk);
        pin_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        expect_val("rise_early", 32'h0);
        expect_val("irq_early", 32'h0);
        peek(BASE + 32'h14, rd, h);
        compare(rd);
        compare(32'(irq));
        @(negedge clk);
        expect_val("rise_set", 32'h04);
        expect_val("irq_set", 32'h1);
        peek(BASE + 32'h14, rd, h);
        compare(rd);
        compare(32'(irq));

        wr(BASE + 32'h14, 32'h04);
        expect_val("rise_w1c", 32'h0);
        expect_val("irq_w1c", 32'h0);
        peek(BASE + 32'h14, rd, h);
        compare(rd);
        compare(32'(irq));

        // Low pulse: sets FALL then RISE
        @(negedge clk);
        pin_in[2] = 1'b0;
        @(negedge clk);
        pin_in[2] = 1'b1;
        repeat (3) @(negedge clk);
        expect_val("pulse_rise", 32'h04);
        expect_val("pulse_fall", 32'h04);
        peek(BASE + 32'h14, rd, h);
        compare(rd);
        @(negedge clk);
        peek(BASE + 32'h18, rd, h);
        compare(rd);

        // Second pulse whose rise lands on the W1C edge
        @(negedge clk);
        pin_in[2] = 1'b0;
        @(negedge clk);
        pin_in[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        addr  = BASE + 32'h14;
        wdata = 32'h04;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
        expect_val("w1c_set_wins", 32'h04);
        peek(BASE + 32'h14, rd, h);
        compare(rd);

        wr(BASE + 32'h14, 32'hFF);
        wr(BASE + 32'h18, 32'hFF);
        expect_val("all_clr_irq", 32'h0);
        #1;
        compare(32'(irq));
`else
        @(negedge clk);
        pin_in[2] = 1'b1;
        repeat (4) @(negedge clk);
        expect_val("rise_absent", 32'h0);
        expect_val("irq_tied", 32'h0);
        peek(BASE + 32'h14, rd, h);
        compare(rd);
        compare(32'(irq));
        expect_val("ch1_rise_absent", 32'h0);
        @(negedge clk);
        peek(BASE + 32'h34, rd, h);
        compare(rd);
`endif

        // Reset mid-operation with ch0 pins held high
        @(negedge clk);
        pin_in[7:0] = 8'hFF;
        resetE      = 1'b0;
        #1;
        expect_val("midrst_pin_out", 32'h0);
        expect_val("midrst_irq", 32'h0);
        compare(32'(pin_out));
        compare(32'(irq));
        repeat (3) @(negedge clk);
        resetE = 1'b1;
        repeat (6) @(negedge clk);
        expect_val("held_in", 32'hFF);
        peek(BASE + 32'h00, rd, h);
        compare(rd);
`ifdef IOBANK_EDGE_EN
        expect_val("held_no_rise", 32'h0);
        expect_val("held_no_irq", 32'h0);
        @(negedge clk);
        peek(BASE + 32'h14, rd, h);
        compare(rd);
        compare(32'(irq));

        @(negedge clk);
        pin_in[7:0] = 8'h00;
        repeat (3) @(negedge clk);
        expect_val("later_fall", 32'hFF);
        expect_val("later_fall_irq", 32'h1);
        peek(BASE + 32'h18, rd, h);
        compare(rd);
        compare(32'(irq));
`else
        expect_val("held_irq_tied", 32'h0);
        compare(32'(irq));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
